// File: rtl/input_4x4_transform_if.sv
// Row-in / tile-out handshake bundle for the 4x4 Winograd input transform.
interface input_4x4_transform_if #(
    parameter int W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [4*W-1:0]    in_row;
    logic              out_valid;
    logic              out_ready;
    logic [16*W-1:0]   out_v;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_v
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_v
    );
endinterface

// File: rtl/input_4x4_transform.sv
// Winograd F(2x2,3x3) input transform V = B^T d B, fed one tile row per beat.
// Define INPUT_TRANSFORM_SAT_EN to saturate results to W bits instead of wrapping.
module input_4x4_transform #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input_4x4_transform_if.slave  bus
);

`ifdef INPUT_TRANSFORM_SAT_EN
    localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};
`endif

    function automatic logic [W-1:0] reduce_w(input logic signed [W+1:0] x);
`ifdef INPUT_TRANSFORM_SAT_EN
        if (x > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return x[W-1:0];
`else
        return x[W-1:0];
`endif
    endfunction

    function automatic logic signed [W+1:0] sx(input logic signed [W:0] a);
        return {a[W], a};
    endfunction

    logic [1:0]          row_cnt_q, row_cnt_d;
    logic signed [W:0]   tbuf_q [4][4];
    logic signed [W:0]   tbuf_d [4][4];
    logic                out_valid_q, out_valid_d;
    logic [16*W-1:0]     out_v_q, out_v_d;

    logic signed [W:0]   lane_x [4];
    logic signed [W:0]   t_new  [4];
    logic signed [W+1:0] v_row  [4][4];
    logic                accept;
    logic                consume;

    // Only the final row of a tile can stall, and only while the previous tile is still held.
    assign bus.in_ready  = !(row_cnt_q == 2'd3 && out_valid_q && !bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign consume       = out_valid_q && bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_v     = out_v_q;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            lane_x[c] = {bus.in_row[W*c+W-1], bus.in_row[W*c +: W]};
        end

        t_new[0] = lane_x[0] - lane_x[2];
        t_new[1] = lane_x[1] + lane_x[2];
        t_new[2] = lane_x[2] - lane_x[1];
        t_new[3] = lane_x[1] - lane_x[3];

        // Row transform uses the buffered t0..t2 and the row-3 result arriving this cycle.
        for (int c = 0; c < 4; c++) begin
            v_row[0][c] = sx(tbuf_q[0][c]) - sx(tbuf_q[2][c]);
            v_row[1][c] = sx(tbuf_q[1][c]) + sx(tbuf_q[2][c]);
            v_row[2][c] = sx(tbuf_q[2][c]) - sx(tbuf_q[1][c]);
            v_row[3][c] = sx(tbuf_q[1][c]) - sx(t_new[c]);
        end

        row_cnt_d   = row_cnt_q;
        tbuf_d      = tbuf_q;
        out_valid_d = out_valid_q;
        out_v_d     = out_v_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            row_cnt_d = row_cnt_q + 2'd1;
            for (int c = 0; c < 4; c++) begin
                tbuf_d[row_cnt_q][c] = t_new[c];
            end
            if (row_cnt_q == 2'd3) begin
                out_valid_d = 1'b1;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        out_v_d[W*(4*r+c) +: W] = reduce_w(v_row[r][c]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt_q   <= 2'd0;
            out_valid_q <= 1'b0;
            out_v_q     <= '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    tbuf_q[r][c] <= '0;
                end
            end
        end else begin
            row_cnt_q   <= row_cnt_d;
            out_valid_q <= out_valid_d;
            out_v_q     <= out_v_d;
            tbuf_q      <= tbuf_d;
        end
    end

endmodule

// File: tb/tb_input_4x4_transform.sv
// Directed and random bench for input_4x4_transform (W=16) with a tile scoreboard.
module tb_input_4x4_transform;

    logic clk;
    logic rstn;

    input_4x4_transform_if #(.W(16)) bus ();

    input_4x4_transform #(.W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [255:0]    exp_q[$];
    logic [3:0][63:0] cur_rows;
    int              tb_row   = 0;
    bit              last_acc;
    bit              last_cons;
    bit              rand_ready = 0;
    int              n_tiles_out = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
            $error("%s observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] model(input logic [3:0][63:0] rows);
        int bt [4][4];
        int d  [4][4];
        int t  [4][4];
        int v;
        logic [31:0] tmp;
        logic [255:0] res;
        bt = '{'{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}};
        res = '0;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++)
                d[i][c] = int'($signed(rows[i][16*c +: 16]));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                t[i][j] = 0;
                for (int k = 0; k < 4; k++) t[i][j] += d[i][k] * bt[j][k];
            end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                v = 0;
                for (int k = 0; k < 4; k++) v += bt[r][k] * t[k][c];
`ifdef INPUT_TRANSFORM_SAT_EN
                if (v > 32767) v = 32767;
                if (v < -32768) v = -32768;
`endif
                tmp = v;
                res[16*(4*r+c) +: 16] = tmp[15:0];
            end
        return res;
    endfunction

    // One clock: sample handshakes at the falling edge, return 1ns after the rising edge.
    task automatic step();
        logic [255:0] e;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        last_acc  = bus.in_valid && bus.in_ready;
        last_cons = bus.out_valid && bus.out_ready;
        if (last_cons) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : {256{1'bx}};
            chk("sb_tile", bus.out_v, e);
            n_tiles_out++;
        end
        if (last_acc) begin
            cur_rows[tb_row] = bus.in_row;
            if (tb_row == 3) exp_q.push_back(model(cur_rows));
            tb_row = (tb_row + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [63:0] row, input int budget, output int cycles);
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!last_acc && cycles < budget);
        if (!last_acc) chk("row_accept_timeout", {255'd0, last_acc}, 256'd1);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [63:0] rnd_row();
        logic [63:0] r;
        for (int c = 0; c < 4; c++) begin
            case ($urandom_range(0, 7))
                0: r[16*c +: 16] = 16'h7FFF;
                1: r[16*c +: 16] = 16'h8000;
                default: r[16*c +: 16] = 16'($urandom());
            endcase
        end
        return r;
    endfunction

    initial begin
        int cyc;
        logic [255:0] vec;
        logic [255:0] expc;
        logic [255:0] tile_a;
        logic [255:0] tile_b;
        logic [3:0][63:0] rows;

        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", {255'd0, bus.in_ready}, 256'd1);
        chk("rst_out_valid", {255'd0, bus.out_valid}, 256'd0);
        chk("rst_out_v", bus.out_v, 256'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {255'd0, bus.in_ready}, 256'd1);

        // Rows all 1, 2, 3, 4
        for (int k = 1; k <= 4; k++) send_row({4{16'(k)}}, 20, cyc);
        chk("ramp_out_valid", {255'd0, bus.out_valid}, 256'd1);
        expc = '0;
        expc[16*1  +: 16] = 16'hFFFC;
        expc[16*5  +: 16] = 16'h000A;
        expc[16*9  +: 16] = 16'h0002;
        expc[16*13 +: 16] = 16'hFFFC;
        chk("ramp_out_v", bus.out_v, expc);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("ramp_consumed", {255'd0, bus.out_valid}, 256'd0);

        // All 0x7FFF
        for (int k = 0; k < 4; k++) send_row({4{16'h7FFF}}, 20, cyc);
        vec = bus.out_v;
`ifdef INPUT_TRANSFORM_SAT_EN
        chk("max_v11", {240'd0, vec[16*5 +: 16]}, {240'd0, 16'h7FFF});
`else
        chk("max_v11", {240'd0, vec[16*5 +: 16]}, {240'd0, 16'hFFFC});
`endif
        chk("max_v01", {240'd0, vec[16*1 +: 16]}, 256'd0);
        chk("max_full", vec, model({4{64'h7FFF7FFF7FFF7FFF}}));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Back-to-back eight rows with the consumer stalled
        for (int k = 0; k < 4; k++) begin
            rows[k] = rnd_row();
            send_row(rows[k], 20, cyc);
        end
        tile_a = model(rows);
        chk("bp_tile_a_valid", {255'd0, bus.out_valid}, 256'd1);
        for (int k = 0; k < 3; k++) begin
            rows[k] = rnd_row();
            send_row(rows[k], 1, cyc);
            chk("bp_row456_one_cycle", {255'd0, last_acc}, 256'd1);
        end
        rows[3] = rnd_row();
        tile_b = model(rows);
        bus.in_valid = 1'b1;
        bus.in_row   = rows[3];
        for (int k = 0; k < 3; k++) begin
            chk("bp_row7_blocked", {255'd0, bus.in_ready}, 256'd0);
            step();
            chk("bp_tile_a_held", bus.out_v, tile_a);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_row7_acc", {255'd0, last_acc}, 256'd1);
        chk("bp_same_cycle_consume", {255'd0, last_cons}, 256'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_valid_kept", {255'd0, bus.out_valid}, 256'd1);
        chk("bp_tile_b", bus.out_v, tile_b);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Reset in the middle of a tile with an output pending
        for (int k = 0; k < 4; k++) send_row(rnd_row(), 20, cyc);
        send_row({4{16'h1234}}, 20, cyc);
        send_row({4{16'h8001}}, 20, cyc);
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", {255'd0, bus.out_valid}, 256'd0);
        chk("midrst_out_v", bus.out_v, 256'd0);
        chk("midrst_in_ready", {255'd0, bus.in_ready}, 256'd1);
        exp_q.delete();
        tb_row = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            rows[k] = rnd_row();
            send_row(rows[k], 20, cyc);
        end
        chk("midrst_tile", bus.out_v, model(rows));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // 1000 random tiles with random gaps on both sides
        n_tiles_out = 0;
        rand_ready  = 1;
        for (int t = 0; t < 1000; t++) begin
            for (int k = 0; k < 4; k++) begin
                while ($urandom_range(0, 3) == 0) step();
                send_row(rnd_row(), 100, cyc);
            end
        end
        rand_ready    = 0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cyc < 20) begin
            step();
            cyc++;
        end
        chk("rand_drain_depth", 256'(exp_q.size()), 256'd0);
        chk("rand_tiles_out", 256'(n_tiles_out), 256'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
